// File: rtl/r2_sdf_pkg.sv
// rtl/r2_sdf_pkg.sv - shared constants and types for the radix-2 SDF stage datapath
// Contents:
//   DEF_WIDTH / DEF_DEPTH / DEF_TW_W  default stage geometry
//   TW_FRAC   fractional bits of a twiddle component (Q2.TW_FRAC)
//   TW_RND    rounding constant added before the twiddle product is shifted down
//   TW_ONE    twiddle value representing 1.0
//   cplx_t / twid_t  complex sample and twiddle at the default widths
//   tw_frac_of()     fractional bits for an arbitrary twiddle width
package r2_sdf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_TW_W  = DEF_WIDTH / 2;

  localparam int TW_FRAC = DEF_TW_W - 2;
  localparam int TW_RND  = 1 << (TW_FRAC - 1);
  localparam int TW_ONE  = 1 << TW_FRAC;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [DEF_TW_W-1:0] re;
    logic signed [DEF_TW_W-1:0] im;
  } twid_t;

  function automatic int tw_frac_of(input int tw_w);
    return tw_w - 2;
  endfunction

endpackage

// File: rtl/r2_sdf_bf_datapath_delay_line.sv
// rtl/r2_sdf_bf_datapath_delay_line.sv - DEPTH-word complex shift register (sdf_delay_line)
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-low clear of every word
//   in_re / in_im   word entering the line (shifted in every clock)
//   out_re / out_im word that entered DEPTH clocks earlier
module sdf_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  logic [WIDTH-1:0] re_q [DEPTH];
  logic [WIDTH-1:0] im_q [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      re_q[0] <= in_re;
      im_q[0] <= in_im;
      for (int i = 1; i < DEPTH; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign out_re = re_q[DEPTH-1];
  assign out_im = im_q[DEPTH-1];

endmodule

// File: rtl/r2_sdf_bf_datapath.sv
// rtl/r2_sdf_bf_datapath.sv - radix-2 SDF FFT stage datapath: delay line, DIF butterfly, twiddle multiply
// Optional feature macro: BF_SCALE_EN (halve butterfly sum and difference for per-stage 1/2 scaling).
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-low reset (delay line and output registers)
//   bf_sel          1 = butterfly phase, 0 = fill/pass phase
//   in_re / in_im   input sample, WIDTH-bit two's complement
//   w_re / w_im     twiddle, signed Q2.(TW_W-2), used when bf_sel=1
//   out_re / out_im registered stage output, one clock after bf_sel/in
module r2_sdf_bf_datapath
  import r2_sdf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TW_W  = WIDTH / 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    bf_sel,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic signed [TW_W-1:0]  w_re,
  input  logic signed [TW_W-1:0]  w_im,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int FRAC = tw_frac_of(TW_W);
  // Full-precision complex product width: one product plus one bit for the add/sub.
  localparam int PW = WIDTH + TW_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);

  logic signed [WIDTH-1:0] a_re, a_im;
  logic signed [WIDTH-1:0] y0_re, y0_im;
  logic signed [WIDTH-1:0] d_re, d_im;
  logic signed [WIDTH-1:0] y1_re, y1_im;
  logic signed [WIDTH-1:0] dly_in_re, dly_in_im;
  logic signed [WIDTH-1:0] out_next_re, out_next_im;
  logic signed [PW-1:0]    m_re, m_im;

  sdf_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay (
    .clock  (clock),
    .reset  (reset),
    .in_re  (dly_in_re),
    .in_im  (dly_in_im),
    .out_re (a_re),
    .out_im (a_im)
  );

`ifdef BF_SCALE_EN
  // Sum/difference formed one bit wider so the halving never sees an overflowed value.
  logic signed [WIDTH:0] s_re, s_im, t_re, t_im;

  always_comb begin
    s_re  = (WIDTH+1)'(a_re) + (WIDTH+1)'(in_re);
    s_im  = (WIDTH+1)'(a_im) + (WIDTH+1)'(in_im);
    t_re  = (WIDTH+1)'(a_re) - (WIDTH+1)'(in_re);
    t_im  = (WIDTH+1)'(a_im) - (WIDTH+1)'(in_im);
    y0_re = WIDTH'(s_re >>> 1);
    y0_im = WIDTH'(s_im >>> 1);
    d_re  = WIDTH'(t_re >>> 1);
    d_im  = WIDTH'(t_im >>> 1);
  end
`else
  always_comb begin
    y0_re = a_re + in_re;
    y0_im = a_im + in_im;
    d_re  = a_re - in_re;
    d_im  = a_im - in_im;
  end
`endif

  // Round-half-up then drop the twiddle fraction; only the low WIDTH bits survive.
  always_comb begin
    m_re  = PW'(d_re) * PW'(w_re) - PW'(d_im) * PW'(w_im) + RND;
    m_im  = PW'(d_re) * PW'(w_im) + PW'(d_im) * PW'(w_re) + RND;
    y1_re = WIDTH'(m_re >>> FRAC);
    y1_im = WIDTH'(m_im >>> FRAC);
  end

  always_comb begin
    if (bf_sel) begin
      out_next_re = y0_re;
      out_next_im = y0_im;
      dly_in_re   = y1_re;
      dly_in_im   = y1_im;
    end else begin
      out_next_re = a_re;
      out_next_im = a_im;
      dly_in_re   = in_re;
      dly_in_im   = in_im;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_re <= '0;
      out_im <= '0;
    end else begin
      out_re <= out_next_re;
      out_im <= out_next_im;
    end
  end

endmodule

// File: tb/tb_r2_sdf_bf_datapath.sv
// tb/tb_r2_sdf_bf_datapath.sv - self-checking bench for r2_sdf_bf_datapath (WIDTH=32, DEPTH=4, TW_W=16)
module tb_r2_sdf_bf_datapath;
  import r2_sdf_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               bf_sel;
  logic signed [31:0] in_re, in_im;
  logic signed [15:0] w_re, w_im;
  logic signed [31:0] out_re, out_im;

  int n_chk  = 0;
  int n_fail = 0;

  int mdl_re [4];
  int mdl_im [4];
  cplx_t sb_q[$];

  always #5 clock = ~clock;

  r2_sdf_bf_datapath #(
    .WIDTH (32),
    .DEPTH (4),
    .TW_W  (16)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bf_sel (bf_sel),
    .in_re  (in_re),
    .in_im  (in_im),
    .w_re   (w_re),
    .w_im   (w_im),
    .out_re (out_re),
    .out_im (out_im)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd_shift(input longint p);
    return int'((p + 64'sd8192) >>> 14);
  endfunction

  task automatic step(input logic rst, input logic bf, input int re, input int im,
                      input shortint wr, input shortint wi);
    int a_re, a_im, y0_re, y0_im, dr, di, y1_re, y1_im, ni_re, ni_im;
    cplx_t e, got;
    reset  = rst;
    bf_sel = bf;
    in_re  = re;
    in_im  = im;
    w_re   = wr;
    w_im   = wi;
    a_re = mdl_re[3];
    a_im = mdl_im[3];
`ifdef BF_SCALE_EN
    y0_re = int'((longint'(a_re) + longint'(re)) >>> 1);
    y0_im = int'((longint'(a_im) + longint'(im)) >>> 1);
    dr    = int'((longint'(a_re) - longint'(re)) >>> 1);
    di    = int'((longint'(a_im) - longint'(im)) >>> 1);
`else
    y0_re = a_re + re;
    y0_im = a_im + im;
    dr    = a_re - re;
    di    = a_im - im;
`endif
    y1_re = rnd_shift(longint'(dr) * wr - longint'(di) * wi);
    y1_im = rnd_shift(longint'(dr) * wi + longint'(di) * wr);
    ni_re = bf ? y1_re : re;
    ni_im = bf ? y1_im : im;
    if (!rst) begin
      e.re = '0;
      e.im = '0;
    end else begin
      e.re = bf ? y0_re : a_re;
      e.im = bf ? y0_im : a_im;
    end
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        mdl_re[i] = 0;
        mdl_im[i] = 0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        mdl_re[i] = mdl_re[i-1];
        mdl_im[i] = mdl_im[i-1];
      end
      mdl_re[0] = ni_re;
      mdl_im[0] = ni_im;
    end
    got = sb_q.pop_front();
    chk("sb_re", out_re, got.re);
    chk("sb_im", out_im, got.im);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 16'sd0, 16'sd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mdl_re[i] = 0;
      mdl_im[i] = 0;
    end

    // Reset held with nonzero input, then idle zeros.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5, 5, 16'sd0, 16'sd0);
      chk("rst_out_re", out_re, 32'd0);
      chk("rst_out_im", out_im, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 0, 0, 16'sd0, 16'sd0);
      chk("idle_out_re", out_re, 32'd0);
    end

    // Pass-through: value driven at step i appears after step i+4.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, i + 1, 0, 16'sd0, 16'sd0);
      if (i >= 4) chk("pass_re", out_re, 32'(i - 3));
      else        chk("pass_pre", out_re, 32'd0);
    end
    zeros(4);

    // Butterfly with w = 1.0.
    step(1'b1, 1'b0, 100, 50, 16'sd0, 16'sd0);
    zeros(3);
    step(1'b1, 1'b1, 30, 10, shortint'(TW_ONE), 16'sd0);
`ifdef BF_SCALE_EN
    chk("bf1_y0_re", out_re, 32'd65);
    chk("bf1_y0_im", out_im, 32'd30);
`else
    chk("bf1_y0_re", out_re, 32'd130);
    chk("bf1_y0_im", out_im, 32'd60);
`endif
    zeros(4);
`ifdef BF_SCALE_EN
    chk("bf1_y1_re", out_re, 32'd35);
    chk("bf1_y1_im", out_im, 32'd20);
`else
    chk("bf1_y1_re", out_re, 32'd70);
    chk("bf1_y1_im", out_im, 32'd40);
`endif

    // Butterfly with w = -j.
    step(1'b1, 1'b0, 100, 50, 16'sd0, 16'sd0);
    zeros(3);
    step(1'b1, 1'b1, 30, 10, 16'sd0, -16'sd16384);
    zeros(4);
`ifdef BF_SCALE_EN
    chk("bfj_y1_re", out_re, 32'd20);
    chk("bfj_y1_im", out_im, -32'sd35);
`else
    chk("bfj_y1_re", out_re, 32'd40);
    chk("bfj_y1_im", out_im, -32'sd70);
`endif

    // Rounding: a-b = +3 then -3 with w = 0.5.
    step(1'b1, 1'b0, 3, 0, 16'sd0, 16'sd0);
    zeros(3);
    step(1'b1, 1'b1, 0, 0, 16'sd8192, 16'sd0);
    step(1'b1, 1'b1, 3, 0, 16'sd8192, 16'sd0);
    zeros(3);
`ifdef BF_SCALE_EN
    chk("rnd_pos", out_re, 32'd1);
`else
    chk("rnd_pos", out_re, 32'd2);
`endif
    zeros(1);
    chk("rnd_neg", out_re, 32'hFFFF_FFFF);

    // Wrap / scaled overflow boundary.
    zeros(4);
    step(1'b1, 1'b0, 32'sh7FFF_FFFF, 0, 16'sd0, 16'sd0);
    zeros(3);
    step(1'b1, 1'b1, 1, 0, shortint'(TW_ONE), 16'sd0);
`ifdef BF_SCALE_EN
    chk("ovf_y0", out_re, 32'h4000_0000);
`else
    chk("ovf_y0", out_re, 32'h8000_0000);
`endif
    zeros(4);

    // Reset mid-operation discards delay contents.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1000 + i, -7, 16'sd0, 16'sd0);
    step(1'b0, 1'b0, 9, 9, 16'sd0, 16'sd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 0, 0, 16'sd0, 16'sd0);
      chk("mid_rst_re", out_re, 32'd0);
    end

    // Random mixed traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), int'($urandom), int'($urandom),
           shortint'($urandom_range(0, 65535)), shortint'($urandom_range(0, 65535)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
